// File: rtl/interrupt_request_servicer_if.sv
// rtl/interrupt_request_servicer_if.sv - CPU/peripheral-facing signal bundle for the interrupt servicer
interface interrupt_request_servicer_if;
  logic [7:0] irq_i;
  logic [7:0] imr_i;
  logic       inta_i;
  logic       eoi_i;
  logic       int_o;
  logic [7:0] pif_clr_o;
  logic [7:0] vector_o;
  logic       vector_valid_o;
  logic [7:0] irr_o;
  logic [7:0] isr_o;

  modport master (
    output irq_i, imr_i, inta_i, eoi_i,
    input  int_o, pif_clr_o, vector_o, vector_valid_o, irr_o, isr_o
  );

  modport slave (
    input  irq_i, imr_i, inta_i, eoi_i,
    output int_o, pif_clr_o, vector_o, vector_valid_o, irr_o, isr_o
  );
endinterface

// File: rtl/interrupt_request_servicer.sv
// rtl/interrupt_request_servicer.sv - 8-source fully nested interrupt controller with two-strobe acknowledge
// Optional feature macro: AUTO_EOI_EN (ISR bit retires itself when the vector is delivered).
module interrupt_request_servicer #(
  parameter logic [4:0] VECTOR_BASE = 5'h08
) (
  input logic                       clk,
  input logic                       rst_n,
  interrupt_request_servicer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACK1 = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [7:0] irq_q, irq_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] winner_q, winner_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic [7:0] pif_clr_q, pif_clr_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;

  logic [7:0] edge_set, isr_low, prio_mask, eligible, win_oh;
  logic [2:0] win_idx;

  // Only sources strictly above the highest-priority in-service level may interrupt.
  always_comb begin
    edge_set  = bus.irq_i & ~irq_q & ~bus.imr_i;
    isr_low   = isr_q & (~isr_q + 8'd1);
    prio_mask = (isr_q == 8'd0) ? 8'hFF : (isr_low - 8'd1);
    eligible  = irr_q & ~bus.imr_i & prio_mask;
    win_oh    = eligible & (~eligible + 8'd1);
    win_idx   = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) win_idx = i[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|eligible)  state_d = PEND;
      PEND:    if (bus.inta_i) state_d = ACK1;
      ACK1:    if (bus.inta_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_d          = bus.irq_i;
    irr_d          = irr_q | edge_set;
    isr_d          = isr_q;
    winner_d       = winner_q;
    spur_d         = spur_q;
    int_d          = (state_d == PEND);
    pif_clr_d      = 8'd0;
    vector_d       = 8'd0;
    vector_valid_d = 1'b0;
    // win_oh is zero on a spurious acknowledge, so IRR/ISR/pif stay untouched.
    if (state_q == PEND && bus.inta_i) begin
      winner_d  = win_idx;
      spur_d    = ~|eligible;
      irr_d     = irr_d & ~win_oh;
      isr_d     = isr_d | win_oh;
      pif_clr_d = win_oh;
    end
    if (state_q == ACK1 && bus.inta_i) begin
      vector_d       = {VECTOR_BASE, winner_q};
      vector_valid_d = 1'b1;
`ifdef AUTO_EOI_EN
      if (!spur_q) isr_d = isr_d & ~(8'd1 << winner_q);
`endif
    end
`ifndef AUTO_EOI_EN
    if (bus.eoi_i) isr_d = isr_d & ~isr_low;
`endif
  end

`ifdef AUTO_EOI_EN
  logic unused_eoi;
  assign unused_eoi = bus.eoi_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q          <= 8'd0;
      irr_q          <= 8'd0;
      isr_q          <= 8'd0;
      winner_q       <= 3'd0;
      spur_q         <= 1'b0;
      int_q          <= 1'b0;
      pif_clr_q      <= 8'd0;
      vector_q       <= 8'd0;
      vector_valid_q <= 1'b0;
    end else begin
      irq_q          <= irq_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      winner_q       <= winner_d;
      spur_q         <= spur_d;
      int_q          <= int_d;
      pif_clr_q      <= pif_clr_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign bus.int_o          = int_q;
  assign bus.pif_clr_o      = pif_clr_q;
  assign bus.vector_o       = vector_q;
  assign bus.vector_valid_o = vector_valid_q;
  assign bus.irr_o          = irr_q;
  assign bus.isr_o          = isr_q;

endmodule

// File: tb/tb_interrupt_request_servicer.sv
// tb/tb_interrupt_request_servicer.sv - directed bench with a vector scoreboard for interrupt_request_servicer
module tb_interrupt_request_servicer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];

`ifdef AUTO_EOI_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  interrupt_request_servicer_if bus_if ();

  interrupt_request_servicer #(.VECTOR_BASE(5'h08)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every delivered vector must match the oldest expectation pushed at the second acknowledge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_if.vector_valid_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_vector", bus_if.vector_o, 8'hxx);
      else                   chk("vector", bus_if.vector_o, exp_q.pop_front());
    end
  end

  task automatic ack1();
    bus_if.inta_i = 1'b1;
    tick();
    bus_if.inta_i = 1'b0;
  endtask

  task automatic ack2(input logic [7:0] exp_vec, input logic with_eoi);
    exp_q.push_back(exp_vec);
    bus_if.inta_i = 1'b1;
    bus_if.eoi_i  = with_eoi;
    tick();
    bus_if.inta_i = 1'b0;
    bus_if.eoi_i  = 1'b0;
    chk("vv_high", {7'd0, bus_if.vector_valid_o}, 8'd1);
    tick();
    chk("vv_one_cycle", {7'd0, bus_if.vector_valid_o}, 8'd0);
  endtask

  task automatic eoi_pulse();
    bus_if.eoi_i = 1'b1;
    tick();
    bus_if.eoi_i = 1'b0;
  endtask

  initial begin
    logic [7:0] left;
    rst_n         = 1'b0;
    bus_if.irq_i  = 8'd0;
    bus_if.imr_i  = 8'd0;
    bus_if.inta_i = 1'b0;
    bus_if.eoi_i  = 1'b0;
    tick();
    tick();
    chk("rst_int", {7'd0, bus_if.int_o}, 8'd0);
    chk("rst_irr", bus_if.irr_o, 8'd0);
    chk("rst_isr", bus_if.isr_o, 8'd0);
    chk("rst_vv", {7'd0, bus_if.vector_valid_o}, 8'd0);
    rst_n = 1'b1;

    // Basic service of IRQ2, with a fresh edge colliding with the acknowledge clear
    bus_if.irq_i = 8'h04;
    tick();
    chk("irr2_set", bus_if.irr_o, 8'h04);
    chk("int_not_yet", {7'd0, bus_if.int_o}, 8'd0);
    tick();
    chk("int_pend", {7'd0, bus_if.int_o}, 8'd1);
    bus_if.irq_i = 8'h00;
    tick();
    bus_if.irq_i = 8'h04;
    ack1();
    chk("pif_clr2", bus_if.pif_clr_o, 8'h04);
    chk("irr_clear_wins", bus_if.irr_o, 8'h00);
    chk("isr2", bus_if.isr_o, 8'h04);
    chk("int_drop", {7'd0, bus_if.int_o}, 8'd0);
    tick();
    chk("pif_one_cycle", bus_if.pif_clr_o, 8'h00);
    ack2(8'h42, 1'b0);
    chk("isr_after_vec", bus_if.isr_o, AUTO ? 8'h00 : 8'h04);
    eoi_pulse();
    chk("eoi_clear", bus_if.isr_o, 8'h00);
    eoi_pulse();
    chk("eoi_empty", bus_if.isr_o, 8'h00);

    // Acknowledge in IDLE does nothing
    bus_if.inta_i = 1'b1;
    tick();
    bus_if.inta_i = 1'b0;
    chk("idle_inta_pif", bus_if.pif_clr_o, 8'h00);
    chk("idle_inta_int", {7'd0, bus_if.int_o}, 8'd0);
    chk("idle_inta_vv", {7'd0, bus_if.vector_valid_o}, 8'd0);

    // Nesting: IRQ0 preempts in-service IRQ5
    bus_if.irq_i = 8'h20;
    tick();
    tick();
    chk("int_irq5", {7'd0, bus_if.int_o}, 8'd1);
    ack1();
    ack2(8'h45, 1'b0);
    chk("isr5", bus_if.isr_o, AUTO ? 8'h00 : 8'h20);
    bus_if.irq_i = 8'h21;
    tick();
    tick();
    chk("int_nest", {7'd0, bus_if.int_o}, 8'd1);
    ack1();
    chk("isr_nest", bus_if.isr_o, AUTO ? 8'h01 : 8'h21);
    ack2(8'h40, 1'b0);
    chk("isr_nest_vec", bus_if.isr_o, AUTO ? 8'h00 : 8'h21);
    eoi_pulse();
    chk("eoi_isr0", bus_if.isr_o, AUTO ? 8'h00 : 8'h20);
    eoi_pulse();
    chk("eoi_isr5", bus_if.isr_o, 8'h00);

    // Spurious acknowledge after masking the pending source
    bus_if.irq_i = 8'h00;
    tick();
    bus_if.irq_i = 8'h08;
    tick();
    tick();
    chk("int_irq3", {7'd0, bus_if.int_o}, 8'd1);
    bus_if.imr_i = 8'h08;
    ack1();
    chk("spur_pif", bus_if.pif_clr_o, 8'h00);
    chk("spur_isr", bus_if.isr_o, 8'h00);
    chk("spur_irr", bus_if.irr_o, 8'h08);
    ack2(8'h47, 1'b0);
    chk("spur_isr_after", bus_if.isr_o, 8'h00);

    // Unmask, begin service, then reset in the middle of the handshake
    bus_if.imr_i = 8'h00;
    tick();
    tick();
    chk("int_irq3_unmask", {7'd0, bus_if.int_o}, 8'd1);
    ack1();
    chk("pif_clr3", bus_if.pif_clr_o, 8'h08);
    rst_n        = 1'b0;
    bus_if.irq_i = 8'h01;
    #1;
    chk("arst_int", {7'd0, bus_if.int_o}, 8'd0);
    chk("arst_pif", bus_if.pif_clr_o, 8'h00);
    chk("arst_vec", bus_if.vector_o, 8'h00);
    chk("arst_vv", {7'd0, bus_if.vector_valid_o}, 8'd0);
    chk("arst_irr", bus_if.irr_o, 8'h00);
    chk("arst_isr", bus_if.isr_o, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("irr0_after_rst", bus_if.irr_o, 8'h01);
    tick();
    ack1();
    ack2(8'h40, 1'b0);
    chk("isr0", bus_if.isr_o, AUTO ? 8'h00 : 8'h01);
    eoi_pulse();
    chk("isr0_eoi", bus_if.isr_o, 8'h00);

    // Held level must not retrigger; EOI coincident with the second acknowledge
    bus_if.irq_i = 8'h02;
    tick();
    tick();
    chk("int_irq1", {7'd0, bus_if.int_o}, 8'd1);
    ack1();
    chk("isr1", bus_if.isr_o, 8'h02);
    ack2(8'h41, 1'b1);
    chk("eoi_with_inta", bus_if.isr_o, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("held_no_int", {7'd0, bus_if.int_o}, 8'd0);
      chk("held_no_irr", bus_if.irr_o, 8'h00);
    end
    bus_if.irq_i = 8'h00;
    tick();
    bus_if.irq_i = 8'h02;
    tick();
    chk("reedge_irr", bus_if.irr_o, 8'h02);
    tick();
    chk("reedge_int", {7'd0, bus_if.int_o}, 8'd1);
    ack1();
    ack2(8'h41, 1'b0);
    eoi_pulse();
    chk("final_isr", bus_if.isr_o, 8'h00);

    tick();
    left = 8'(exp_q.size());
    chk("scoreboard_drained", left, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_request_servicer.md
INTERRUPT_REQUEST_SERVICER -- requirements
Module: interrupt_request_servicer

Interface
REQ-001 Parameter: VECTOR_BASE, default 5'h08, upper five bits of every returned interrupt vector.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low; synchronous deassert is the system's responsibility.
REQ-004 irq_i  input  8  peripheral interrupt flags (pif), one per source; bit 0 is highest priority.
REQ-005 imr_i  input  8  mask; bit=1 blocks the corresponding source from being sampled into IRR.
REQ-006 inta_i  input  1  CPU acknowledge strobe, one cycle high per acknowledge.
REQ-007 eoi_i  input  1  end-of-interrupt strobe, one cycle high.
REQ-008 int_o  output  1  interrupt request to CPU, registered.
REQ-009 pif_clr_o  output  8  one-cycle clear pulse back to the peripheral flag of the serviced source.
REQ-010 vector_o  output  8  interrupt vector; valid only while vector_valid_o=1.
REQ-011 vector_valid_o  output  1  one-cycle vector qualifier.
REQ-012 irr_o, isr_o  output  8 each  request and in-service registers, for debug.

Function
REQ-013 irq_i SHALL be edge-detected against a registered copy; IRR[n] SHALL set on the edge where irq_i[n] is 1, its previous sample is 0, and imr_i[n] is 0.
REQ-014 A level held high SHALL NOT re-set IRR; a new 0->1 transition SHALL be required.
REQ-015 A source SHALL be eligible when IRR[n]=1, imr_i[n]=0, and n is strictly higher priority than the lowest-numbered set ISR bit (fully nested mode).
REQ-016 FSM states: IDLE, PEND, ACK1. Reset state SHALL be IDLE.
REQ-017 IDLE->PEND when any source is eligible; int_o SHALL be 1 exactly while in PEND, one cycle after IRR sets.
REQ-018 PEND with inta_i=1: winner n = lowest-numbered eligible source; ISR[n] set, IRR[n] cleared, pif_clr_o[n]=1 for the next cycle only, transition to ACK1.
REQ-019 If no source is eligible at the first acknowledge (spurious), n=7 SHALL be used, with no ISR/IRR change and no pif_clr_o pulse.
REQ-020 ACK1 with inta_i=1: vector_o={VECTOR_BASE,n[2:0]}, vector_valid_o=1 for one cycle, transition to IDLE.
REQ-021 inta_i SHALL be ignored in IDLE; requests arriving during ACK1 SHALL be held in IRR and serviced after return to IDLE.
REQ-022 eoi_i SHALL clear the lowest-numbered set ISR bit; when ISR=0 it SHALL have no effect.
REQ-023 Simultaneous edge-set and ACK-clear of the same IRR bit: clear SHALL win.
REQ-024 eoi_i coincident with the second inta_i: both effects SHALL apply in the same cycle.

Reset
REQ-025 rst_n=0 SHALL immediately clear IRR, ISR, the edge-sample register, int_o, pif_clr_o, vector_o, and vector_valid_o, and force IDLE, including mid-handshake.
REQ-026 The first edge after release SHALL compare against an all-zero sample, so a level already high sets IRR.

Configuration
REQ-027 Macro AUTO_EOI_EN. When defined: ISR[n] SHALL clear in the same cycle vector_valid_o asserts, and eoi_i SHALL be ignored. When undefined: ISR clears only via eoi_i (REQ-022).

Verification
REQ-028 irq_i=8'h04 rising, imr=0: int_o=1 one cycle after IRR[2] sets; inta -> pif_clr_o=8'h04 for one cycle; second inta -> vector_o=8'h42, vector_valid_o=1 for one cycle.
REQ-029 irq_i 8'h20 then 8'h21 while ISR[5] set: IRQ0 nests and yields vector 8'h40; eoi clears ISR[0], then a second eoi clears ISR[5].
REQ-030 IRR[3] set, then imr_i=8'h08 before first inta: spurious path -> vector_o=8'h47, ISR unchanged, pif_clr_o=0.
REQ-031 rst_n low in ACK1: all outputs 0 immediately; irq_i held 8'h01 through release -> IRR[0] set on the first edge after release.
REQ-032 irq_i[1] held high after service without a falling edge: no second int_o; low then high -> int_o reasserts.
REQ-033 AUTO_EOI_EN defined: ISR=0 on the cycle after vector_valid_o; eoi_i pulse has no effect.
